// File: rtl/data_ram_pkg.sv
// Shared sizing constants and derivations for the byte-addressed data RAM.
package data_ram_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;

  // Number of bytes held by one storage word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte inside a word.
  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Width of the word index taken from the upper address bits.
  function automatic int word_idx_width(input int addr_width, input int data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/data_ram.sv
// Byte-addressed, word-organised data RAM: clocked full-word writes,
// combinational reads, asynchronous clear of every word on rst.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  addr_misaligned
);

  localparam int OFFSET_BITS = offset_bits(DATA_WIDTH);
  localparam int IDX_WIDTH   = word_idx_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int NUM_WORDS   = 2 ** IDX_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
  logic [IDX_WIDTH-1:0]  w_word_idx;

  // Byte-offset bits are dropped: every address inside a word hits that word.
  assign w_word_idx = addr[ADDR_WIDTH-1:OFFSET_BITS];

  // Storage: cleared asynchronously while rst is high, so writes during reset are lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (mem_write) begin
      r_mem[w_word_idx] <= write_data;
    end else begin
      r_mem[w_word_idx] <= r_mem[w_word_idx];
    end
  end

  // Read mux: zero-latency, no bypass of a same-cycle write, zero when not reading.
  always_comb begin
    read_data = '0;
    if (mem_read) begin
      read_data = r_mem[w_word_idx];
    end else begin
      read_data = '0;
    end
  end

  generate
    if (OFFSET_BITS > 0) begin : g_offset
      // Misalignment flag depends only on the byte-offset bits of addr.
      always_comb begin
        addr_misaligned = 1'b0;
        if (addr[OFFSET_BITS-1:0] != '0) begin
          addr_misaligned = 1'b1;
        end else begin
          addr_misaligned = 1'b0;
        end
      end
    end else begin : g_no_offset
      // Byte-wide words can never be misaligned.
      always_comb begin
        addr_misaligned = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram with hand-computed expectations.
module tb_data_ram;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic        mem_read;
  logic [9:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        addr_misaligned;

  int n_checks;
  int n_pass;

  data_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .addr            (addr),
    .write_data      (write_data),
    .read_data       (read_data),
    .addr_misaligned (addr_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Single-cycle write launched at a falling edge, committed at the next rising edge.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    addr       = a;
    write_data = d;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  // Combinational read: set address, wait 1 ns, compare.
  task automatic read_check(input string tag, input logic [9:0] a, input logic [31:0] exp);
    addr     = a;
    mem_read = 1'b1;
    #1;
    check_eq(tag, read_data, exp);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    mem_write  = 1'b0;
    mem_read   = 1'b1;
    addr       = 10'd0;
    write_data = 32'd0;

    // Reset state
    #12;
    check_eq("reset_read0", read_data, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_reset_read0", read_data, 32'h0000_0000);

    // Basic write/read
    do_write(10'd0, 32'hDEAD_BEEF);
    read_check("read_a0", 10'd0, 32'hDEAD_BEEF);
    do_write(10'd4, 32'hCAFE_BABE);
    read_check("read_a4", 10'd4, 32'hCAFE_BABE);
    read_check("reread_a0", 10'd0, 32'hDEAD_BEEF);

    // Read disabled, misalignment
    mem_read = 1'b0;
    addr     = 10'd4;
    #1;
    check_eq("read_disabled", read_data, 32'h0000_0000);
    check_eq("aligned_a4", {31'd0, addr_misaligned}, 32'd0);
    addr = 10'd7;
    #1;
    check_eq("misaligned_noread_a7", {31'd0, addr_misaligned}, 32'd1);
    read_check("misaligned_read_a6", 10'd6, 32'hCAFE_BABE);
    check_eq("misaligned_flag_a6", {31'd0, addr_misaligned}, 32'd1);
    read_check("offset_read_a5", 10'd5, 32'hCAFE_BABE);

    // Same-cycle read and write: old data before edge, new after, no bypass
    @(negedge clk);
    addr       = 10'd8;
    write_data = 32'h1234_5678;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    #1;
    check_eq("rw_before_edge", read_data, 32'h0000_0000);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    check_eq("rw_after_edge", read_data, 32'h1234_5678);

    // Misaligned write lands in the containing word
    do_write(10'd14, 32'h0BAD_F00D);
    read_check("misaligned_write_a12", 10'd12, 32'h0BAD_F00D);

    // mem_write=0 leaves contents unchanged across an edge
    @(negedge clk);
    addr       = 10'd0;
    write_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    read_check("no_write_hold_a0", 10'd0, 32'hDEAD_BEEF);

    // Write with mem_read=0 still stores
    mem_read = 1'b0;
    do_write(10'd16, 32'h5555_AAAA);
    read_check("write_noread_a16", 10'd16, 32'h5555_AAAA);

    // Top word
    do_write(10'd1020, 32'hA5A5_A5A5);
    read_check("top_word_a1020", 10'd1020, 32'hA5A5_A5A5);
    read_check("top_word_a1023", 10'd1023, 32'hA5A5_A5A5);

    // Asynchronous reset pulse with a write attempted during reset
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("during_rst_a1020", read_data, 32'h0000_0000);
    addr       = 10'd24;
    write_data = 32'h7777_7777;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #2;
    rst = 1'b0;
    read_check("after_rst_a0", 10'd0, 32'h0000_0000);
    read_check("after_rst_a4", 10'd4, 32'h0000_0000);
    read_check("after_rst_a1020", 10'd1020, 32'h0000_0000);
    read_check("after_rst_a24", 10'd24, 32'h0000_0000);

    // First write after reset is honoured
    do_write(10'd20, 32'h0000_0011);
    read_check("first_write_after_rst", 10'd20, 32'h0000_0011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter ADDR_WIDTH, default 10: byte-address width, giving 2**ADDR_WIDTH bytes (1024 by default).
REQ-003 Parameter DATA_WIDTH, default 32: word width; SHALL be a multiple of 8.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 mem_write  input  1  write enable, sampled on rising clk.
REQ-007 mem_read  input  1  read enable, combinational.
REQ-008 addr  input  ADDR_WIDTH  byte address, shared by read and write.
REQ-009 write_data  input  DATA_WIDTH  word to store.
REQ-010 read_data  output  DATA_WIDTH  word read out.
REQ-011 addr_misaligned  output  1  high when the low log2(DATA_WIDTH/8) bits of addr are non-zero; may be left unconnected.

Function
REQ-012 Storage: 2**ADDR_WIDTH/(DATA_WIDTH/8) words (256 x 32 by default), indexed by word_idx = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
- Low offset bits are ignored for storage; address 5 accesses the same word as address 4.
REQ-013 Write: on rising clk with mem_write=1 and rst=0, mem[word_idx] SHALL take write_data; the full word is written, with no byte enables.
REQ-014 Read: combinational, zero-cycle latency; read_data = mem[word_idx] when mem_read=1, else all zeros.
REQ-015 Read and write in the same cycle to the same word: read_data SHALL show the old contents until the clock edge, then the new contents; there is no write-through bypass.
REQ-016 Read and write to different words in the same cycle SHALL not interact.
REQ-017 addr_misaligned SHALL be purely combinational from addr and independent of mem_read and mem_write.
- Misaligned accesses still complete using word_idx.
REQ-018 Top word (addr 1020 with defaults) SHALL be fully usable; there is no wrap or out-of-range condition because the address space equals the storage.
REQ-019 mem_write=0 SHALL leave all contents unchanged.
- A write with mem_read=0 still updates memory.

Reset
REQ-020 While rst=1, every memory word SHALL be cleared to zero asynchronously, and read_data SHALL read zero.
REQ-021 A write request while rst=1 SHALL be ignored, including at a clock edge coinciding with reset.
REQ-022 After rst falls, the first write SHALL occur at the next qualifying rising clk edge.
REQ-023 A reset asserted mid-operation SHALL discard any contents written earlier.

Structure
REQ-024 Package data_ram_pkg SHALL hold:
- default ADDR_WIDTH (10) and DATA_WIDTH (32);
- BYTES_PER_WORD and OFFSET_BITS as a function of DATA_WIDTH;
- the word-index width derivation.
REQ-025 The design SHALL be a single module with no sub-module.
- Storage is a register array written in one always_ff with asynchronous rst.
- Read mux and misalignment check are in always_comb.

Verification
REQ-026 Write 0xDEADBEEF at addr 0, then read addr 0 with mem_read=1 -> read_data=0xDEADBEEF within 1 ns, with no clock edge needed.
REQ-027 Write 0xCAFEBABE at addr 4, then read addr 4 -> 0xCAFEBABE; re-read addr 0 -> 0xDEADBEEF, unchanged.
REQ-028 mem_read=0 at addr 4 -> read_data=0; addr 6 -> addr_misaligned=1 and mem_read=1 returns 0xCAFEBABE.
REQ-029 mem_read=1 and mem_write=1 at addr 8 with 0x12345678 over old value 0 -> read_data=0 before the edge and 0x12345678 after it.
REQ-030 Write 0xA5A5A5A5 at addr 1020, then pulse rst asynchronously between clock edges -> reads of addrs 0, 4 and 1020 return 0 afterwards; a write attempted during rst has no effect.
